// File: rtl/udp_aggregator_param_if.sv
// ---------------------------------------------------------------------------
// udp_aggregator_param_if
// Handshake bundle between a packet source/result sink and the
// udp_aggregator_param block.
//   In_data   [DATA_W] packet beat             (master -> slave)
//   In_valid           beat valid              (master -> slave)
//   In_last            final beat of packet    (master -> slave)
//   In_ready           beat accepted           (slave  -> master)
//   Out_data  [DATA_W] result word             (slave  -> master)
//   Out_valid          result available        (slave  -> master)
//   Out_ready          result consumed         (master -> slave)
// ---------------------------------------------------------------------------
interface udp_aggregator_param_if #(
  parameter int DATA_W = 256
);
  logic [DATA_W-1:0] In_data;
  logic              In_valid;
  logic              In_last;
  logic              In_ready;
  logic [DATA_W-1:0] Out_data;
  logic              Out_valid;
  logic              Out_ready;

  modport master (
    output In_data, In_valid, In_last, Out_ready,
    input  In_ready, Out_data, Out_valid
  );

  modport slave (
    input  In_data, In_valid, In_last, Out_ready,
    output In_ready, Out_data, Out_valid
  );
endinterface

// File: rtl/udp_aggregator_param.sv
// ---------------------------------------------------------------------------
// udp_aggregator_param
// Receives packets as DATA_W-bit beats (header beat, opcode beat, body
// beats), folds the 32-bit payload words with SUM / MAX / MIN according to
// the opcode and pushes one result entry per packet into a RES_DEPTH-entry
// result FIFO.
//   clk        single clock, rising edge
//   reset      asynchronous active-high reset
//   bus        udp_aggregator_param_if.slave (In_* beat stream, Out_* results)
//   pkt_count  [16] results pushed, saturating   (only with UDP_AGG_STATS_EN)
//   drop_count [16] dropped + errored packets    (only with UDP_AGG_STATS_EN)
// Result entry: [31:0] result, [47:32] opcode, [48] error, rest zero.
// Optional feature macro: UDP_AGG_STATS_EN adds the two statistics counters.
// ---------------------------------------------------------------------------
module udp_aggregator_param #(
  parameter int DATA_W    = 256,
  parameter int RES_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  udp_aggregator_param_if.slave bus
`ifdef UDP_AGG_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] drop_count
`endif
);

  localparam int WORDS     = DATA_W / 32;
  localparam int OPC_WORDS = 5;
  localparam int PTR_W     = $clog2(RES_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {HDR, OPC, BODY} rx_state_t;

  rx_state_t         state, state_nxt;
  logic [31:0]       acc, fold_val;
  logic [15:0]       opcode, cur_op;
  logic              cur_err;
  logic              accept, push, pop;
  logic              ready_en;
  logic [DATA_W-1:0] entry;
  logic [DATA_W-1:0] fifo_mem [RES_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;

  function automatic logic [31:0] init_val(input logic [15:0] op);
    return (op == 16'd3) ? 32'hFFFF_FFFF : 32'h0;
  endfunction

  // Unknown opcodes collapse to 0 so an errored packet carries a zero result.
  function automatic logic [31:0] fold_word(input logic [15:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] w);
    case (op)
      16'd1:   return a + w;
      16'd2:   return (w > a) ? w : a;
      16'd3:   return (w < a) ? w : a;
      default: return 32'h0;
    endcase
  endfunction

  assign accept = bus.In_valid && bus.In_ready;
  assign pop    = bus.Out_valid && bus.Out_ready;

  // ready_en keeps In_ready low during reset and until the first clock edge.
  assign bus.In_ready  = ready_en && (count < CNT_W'(RES_DEPTH));
  assign bus.Out_valid = (count != '0);
  assign bus.Out_data  = bus.Out_valid ? fifo_mem[rd_ptr] : '0;

  // Next state and folding. The opcode beat restarts the accumulator from
  // the initial value of the newly seen opcode, so packets never interact.
  always_comb begin
    state_nxt = state;
    cur_op    = opcode;
    fold_val  = acc;
    push      = 1'b0;
    case (state)
      HDR: begin
        if (accept && !bus.In_last) state_nxt = OPC;
      end
      OPC: begin
        if (accept) begin
          cur_op    = bus.In_data[175:160];
          fold_val  = init_val(bus.In_data[175:160]);
          push      = bus.In_last;
          state_nxt = bus.In_last ? HDR : BODY;
        end
      end
      BODY: begin
        if (accept && bus.In_last) begin
          push      = 1'b1;
          state_nxt = HDR;
        end
      end
      default: state_nxt = HDR;
    endcase
    for (int i = 0; i < WORDS; i++) begin
      if (accept && ((state == BODY) || (state == OPC && i < OPC_WORDS)))
        fold_val = fold_word(cur_op, fold_val, bus.In_data[i*32 +: 32]);
    end
  end

  assign cur_err = !((cur_op == 16'd1) || (cur_op == 16'd2) || (cur_op == 16'd3));

  always_comb begin
    entry          = '0;
    entry[31:0]    = cur_err ? 32'h0 : fold_val;
    entry[47:32]   = cur_op;
    entry[48]      = cur_err;
  end

  // RX state, accumulator and latched opcode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= HDR;
      acc      <= '0;
      opcode   <= '0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= fold_val;
      opcode   <= cur_op;
      ready_en <= 1'b1;
    end
  end

  // Result FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: Out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= entry;
  end

`ifdef UDP_AGG_STATS_EN
  logic drop;
  assign drop = accept && (state == HDR) && bus.In_last;

  // Saturating statistics; errored packets count as both pushed and dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (push && pkt_count != 16'hFFFF)
        pkt_count <= pkt_count + 16'd1;
      if ((drop || (push && cur_err)) && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_udp_aggregator_param.sv
// ---------------------------------------------------------------------------
// tb_udp_aggregator_param
// Directed bench for udp_aggregator_param (DATA_W=256, RES_DEPTH=2).
// Expected result entries are queued when a packet is issued; a monitor pops
// and compares them whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_udp_aggregator_param;
  localparam int DATA_W    = 256;
  localparam int RES_DEPTH = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] mon_exp;
  logic [DATA_W-1:0] hdr;
  logic [DATA_W-1:0] beat;

  always #5 clk = ~clk;

  udp_aggregator_param_if #(.DATA_W(DATA_W)) bus ();

`ifdef UDP_AGG_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
`endif

  udp_aggregator_param #(.DATA_W(DATA_W), .RES_DEPTH(RES_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef UDP_AGG_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
`endif
  );

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fill(input logic [31:0] v);
    return {8{v}};
  endfunction

  // Opcode beat; unused upper bits carry junk that must not be folded.
  function automatic logic [DATA_W-1:0] opcBeat(input logic [15:0] op,
      input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
      input logic [31:0] w3, input logic [31:0] w4);
    logic [DATA_W-1:0] b;
    b = {8{32'hDEAD_BEEF}};
    b[31:0]    = w0;
    b[63:32]   = w1;
    b[95:64]   = w2;
    b[127:96]  = w3;
    b[159:128] = w4;
    b[175:160] = op;
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] expEntry(input logic err,
      input logic [15:0] op, input logic [31:0] res);
    logic [DATA_W-1:0] e;
    e = '0;
    e[31:0]  = res;
    e[47:32] = op;
    e[48]    = err;
    return e;
  endfunction

  // Drives one beat and returns #1 after the edge that accepted it.
  task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic last,
                               input string name);
    logic rdy;
    bit   accepted;
    accepted     = 0;
    bus.In_data  = data;
    bus.In_valid = 1'b1;
    bus.In_last  = last;
    for (int c = 0; c < 200 && !accepted; c++) begin
      @(negedge clk);
      rdy = bus.In_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) accepted = 1;
    end
    bus.In_valid = 1'b0;
    bus.In_last  = 1'b0;
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s accept_timeout actual=0 required=1", name);
    end
  endtask

  task automatic waitDrain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s pending_results actual=%0d required=0", name, exp_q.size());
    end
  endtask

  // Monitor: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.Out_valid === 1'b1 && bus.Out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result actual=%h required=none", bus.Out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("result", bus.Out_data, mon_exp);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hdr           = fill(32'h4500_1C11);
    bus.In_data   = '0;
    bus.In_valid  = 1'b0;
    bus.In_last   = 1'b0;
    bus.Out_ready = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", bus.Out_valid, 0);
    checkOutput("reset_out_data", bus.Out_data, 0);
    checkOutput("reset_in_ready", bus.In_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("in_ready_after_reset", bus.In_ready, 1);

    // SUM 1..5 + 8 x 2 = 31, with idle cycles between beats.
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'd31));
    applyStimulus(hdr, 1'b0, "a_hdr");
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(opcBeat(16'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b0, "a_opc");
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(fill(32'd2), 1'b1, "a_body");
    checkOutput("latency_out_valid", bus.Out_valid, 1);
    waitDrain("a_drain");

    // MIN with a single 7 among 0x100 words.
    exp_q.push_back(expEntry(1'b0, 16'd3, 32'd7));
    applyStimulus(hdr, 1'b0, "b_hdr");
    applyStimulus(opcBeat(16'd3, 32'h100, 32'h100, 32'h100, 32'h100, 32'h100), 1'b0, "b_opc");
    beat = fill(32'h100);
    beat[127:96] = 32'd7;
    applyStimulus(beat, 1'b1, "b_body");

    // SUM of 13 x 0xFFFFFFFF wraps to 0xFFFFFFF3.
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'hFFFF_FFF3));
    applyStimulus(hdr, 1'b0, "c_hdr");
    applyStimulus(opcBeat(16'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                          32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b0, "c_opc");
    applyStimulus(fill(32'hFFFF_FFFF), 1'b1, "c_body");
    waitDrain("bc_drain");

    // MAX ending on the opcode beat: only the five low words count.
    exp_q.push_back(expEntry(1'b0, 16'd2, 32'd9));
    applyStimulus(hdr, 1'b0, "d_hdr");
    applyStimulus(opcBeat(16'd2, 32'd5, 32'd9, 32'd3, 32'd1, 32'd2), 1'b1, "d_opc");
    waitDrain("d_drain");

    // Unknown opcode gives error entry; header-only packet gives nothing.
    exp_q.push_back(expEntry(1'b1, 16'd9, 32'd0));
    applyStimulus(hdr, 1'b0, "e_hdr");
    applyStimulus(opcBeat(16'd9, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b0, "e_opc");
    applyStimulus(fill(32'd7), 1'b1, "e_body");
    waitDrain("e_drain");
    applyStimulus(hdr, 1'b1, "hdr_only");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hdr_only_no_result", bus.Out_valid, 0);
`ifdef UDP_AGG_STATS_EN
    checkOutput("drop_count", drop_count, 16'd2);
    checkOutput("pkt_count", pkt_count, 16'd5);
`endif

    // Backpressure: two results fill the FIFO, the third packet stalls.
    bus.Out_ready = 1'b0;
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'd5));
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'd50));
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'd500));
    applyStimulus(hdr, 1'b0, "p1_hdr");
    applyStimulus(opcBeat(16'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1), 1'b1, "p1_opc");
    applyStimulus(hdr, 1'b0, "p2_hdr");
    applyStimulus(opcBeat(16'd1, 32'd10, 32'd10, 32'd10, 32'd10, 32'd10), 1'b1, "p2_opc");
    checkOutput("full_in_ready", bus.In_ready, 0);
    checkOutput("full_head", bus.Out_data, expEntry(1'b0, 16'd1, 32'd5));
    fork
      begin
        applyStimulus(hdr, 1'b0, "p3_hdr");
        applyStimulus(opcBeat(16'd1, 32'd100, 32'd100, 32'd100, 32'd100, 32'd100),
                      1'b1, "p3_opc");
      end
      begin
        repeat (4) @(negedge clk);
        checkOutput("stall_in_ready", bus.In_ready, 0);
        checkOutput("hold_out_valid", bus.Out_valid, 1);
        checkOutput("hold_out_data", bus.Out_data, expEntry(1'b0, 16'd1, 32'd5));
        @(posedge clk);
        #1;
        bus.Out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.Out_ready = 1'b0;
      end
    join
    bus.Out_ready = 1'b1;
    waitDrain("p_drain");

    // Reset in the middle of a body beat sequence with a result pending.
    bus.Out_ready = 1'b0;
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'd5));
    applyStimulus(hdr, 1'b0, "r1_hdr");
    applyStimulus(opcBeat(16'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1), 1'b1, "r1_opc");
    checkOutput("pre_reset_out_valid", bus.Out_valid, 1);
    applyStimulus(hdr, 1'b0, "r2_hdr");
    applyStimulus(opcBeat(16'd1, 32'd100, 32'd200, 32'd300, 32'd400, 32'd500), 1'b0, "r2_opc");
    applyStimulus(fill(32'd1000), 1'b0, "r2_body");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_out_valid", bus.Out_valid, 0);
    checkOutput("mid_reset_out_data", bus.Out_data, 0);
    checkOutput("mid_reset_in_ready", bus.In_ready, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.Out_ready = 1'b1;
    exp_q.push_back(expEntry(1'b0, 16'd1, 32'd15));
    applyStimulus(hdr, 1'b0, "r3_hdr");
    applyStimulus(opcBeat(16'd1, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5), 1'b1, "r3_opc");
    waitDrain("r_drain");
`ifdef UDP_AGG_STATS_EN
    checkOutput("post_reset_drop_count", drop_count, 16'd0);
    checkOutput("post_reset_pkt_count", pkt_count, 16'd1);
`endif

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
